// File: rtl/apb_spi_pkg.sv
// Shared constants, register addresses/masks and state encodings for the
// APB-attached SPI FIFO register block.
package apb_spi_pkg;

    localparam logic [2:0] ADDR_CR1  = 3'd0;
    localparam logic [2:0] ADDR_CR2  = 3'd1;
    localparam logic [2:0] ADDR_BR   = 3'd2;
    localparam logic [2:0] ADDR_SR   = 3'd3;
    localparam logic [2:0] ADDR_CNT  = 3'd4;
    localparam logic [2:0] ADDR_DR   = 3'd5;
    localparam logic [2:0] ADDR_RXTH = 3'd6;

    localparam logic [7:0] CR1_RESET = 8'h04;
    localparam logic [7:0] CR2_WMASK = 8'h1B;
    localparam logic [7:0] BR_WMASK  = 8'h77;

    localparam int CR1_SPIE  = 7;
    localparam int CR1_SPE   = 6;
    localparam int CR1_SPTIE = 5;
    localparam int CR1_MSTR  = 4;
    localparam int CR1_CPOL  = 3;
    localparam int CR1_CPHA  = 2;
    localparam int CR1_SSOE  = 1;
    localparam int CR1_LSBFE = 0;

    localparam int CR2_MODFEN  = 4;
    localparam int CR2_SPISWAI = 1;

    localparam int SR_SPIF   = 7;
    localparam int SR_SPTEF  = 5;
    localparam int SR_MODF   = 4;
    localparam int SR_RXOVF  = 3;
    localparam int SR_TXFULL = 2;
    localparam int SR_RXTH   = 1;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'b00,
        APB_SETUP  = 2'b01,
        APB_ACCESS = 2'b10
    } apb_state_t;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'b00,
        MODE_WAIT = 2'b01,
        MODE_STOP = 2'b10
    } spi_mode_t;

    // CNT nibbles cannot show 16, so a full 16-deep FIFO reads as 15.
    function automatic logic [3:0] sat4(input logic [7:0] c);
        return (c > 8'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with flush; a pop frees the slot a same-cycle push needs,
// so push+pop on a full FIFO both succeed.
module spi_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/apb_spi_fifo_if.sv
// APB register front end for an SPI block with TX/RX FIFOs and low-power modes.
// Define APB_SPI_RX_THRESH_EN to add the RXTH register (address 6) and rxth flag.
module apb_spi_fifo_if
    import apb_spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [2:0]        PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              tip,
    input  logic              ss_n,
    output logic [3:0]        spi_cfg,
    output logic [2:0]        sppr,
    output logic [2:0]        spr,
    output logic [1:0]        spi_mode,
    output logic              irq,
    output logic [1:0]        apb_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    apb_state_t        apb_q;
    spi_mode_t         mode_q;
    logic [7:0]        cr1, cr2, br;
    logic              rxovf, spe_q, irq_q;
    logic [7:0]        sr;
    logic              modf, rxth, flush, spe;
    logic [DATA_W-1:0] rd_val;
    logic              acc_err;
    logic              commit, wr_commit, tx_push, rx_pop;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]     tx_count, rx_count;
    logic [DATA_W-1:0] rx_head;
    logic              irq_next;
`ifdef APB_SPI_RX_THRESH_EN
    logic [7:0]        rxth_q;
`endif

    assign spe   = cr1[CR1_SPE];
    assign flush = spe_q & ~spe;
    assign modf  = ~ss_n & cr1[CR1_MSTR] & cr2[CR2_MODFEN] & ~cr1[CR1_SSOE];
`ifdef APB_SPI_RX_THRESH_EN
    assign rxth  = (8'(rx_count) >= rxth_q) && (rxth_q != 8'd0);
`else
    assign rxth  = 1'b0;
`endif
    assign sr = {~rx_empty, 1'b0, tx_empty, modf, rxovf, tx_full, rxth, 1'b0};

    assign PREADY    = (apb_q == APB_ACCESS);
    assign apb_state = apb_q;
    // PSLVERR was latched on entry to ACCESS, so it also gates the commit.
    assign commit    = (apb_q == APB_ACCESS) & ~PSLVERR;
    assign wr_commit = commit & PWRITE;
    assign tx_push   = wr_commit & (PADDR == ADDR_DR);
    assign rx_pop    = commit & ~PWRITE & (PADDR == ADDR_DR);

    assign tx_valid = ~tx_empty & spe & (mode_q != MODE_STOP);
    assign spi_cfg  = {cr1[CR1_MSTR], cr1[CR1_CPOL], cr1[CR1_CPHA], cr1[CR1_LSBFE]};
    assign sppr     = br[6:4];
    assign spr      = br[2:0];
    assign spi_mode = mode_q;
    assign irq      = irq_q;
    assign irq_next = (cr1[CR1_SPIE] & (sr[SR_SPIF] | sr[SR_MODF] | sr[SR_RXOVF] | sr[SR_RXTH]))
                    | (cr1[CR1_SPTIE] & sr[SR_SPTEF]);

    always_comb begin
        rd_val  = '0;
        acc_err = 1'b0;
        case (PADDR)
            ADDR_CR1: begin rd_val = DATA_W'(cr1); acc_err = PWRITE & tip; end
            ADDR_CR2: begin rd_val = DATA_W'(cr2); acc_err = PWRITE & tip; end
            ADDR_BR:  begin rd_val = DATA_W'(br);  acc_err = PWRITE & tip; end
            ADDR_SR:  rd_val = DATA_W'(sr);
            ADDR_CNT: rd_val = DATA_W'({sat4(8'(rx_count)), sat4(8'(tx_count))});
            ADDR_DR: begin
                if (PWRITE) begin
                    acc_err = tx_full;
                end else begin
                    acc_err = rx_empty;
                    rd_val  = rx_empty ? '0 : rx_head;
                end
            end
`ifdef APB_SPI_RX_THRESH_EN
            ADDR_RXTH: rd_val = DATA_W'(rxth_q);
`endif
            default:  acc_err = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            apb_q   <= APB_IDLE;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else begin
            case (apb_q)
                APB_IDLE: begin
                    if (PSEL && !PENABLE) apb_q <= APB_SETUP;
                end
                APB_SETUP: begin
                    if (PSEL && PENABLE) begin
                        apb_q   <= APB_ACCESS;
                        PSLVERR <= acc_err;
                        PRDATA  <= PWRITE ? '0 : rd_val;
                    end else if (!PSEL) begin
                        apb_q <= APB_IDLE;
                    end
                end
                APB_ACCESS: begin
                    apb_q   <= PSEL ? APB_SETUP : APB_IDLE;
                    PRDATA  <= '0;
                    PSLVERR <= 1'b0;
                end
                default: apb_q <= APB_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            mode_q <= MODE_RUN;
        end else begin
            case (mode_q)
                MODE_RUN:  if (!spe) mode_q <= MODE_WAIT;
                MODE_WAIT: begin
                    if (spe)                    mode_q <= MODE_RUN;
                    else if (cr2[CR2_SPISWAI])  mode_q <= MODE_STOP;
                end
                MODE_STOP: begin
                    if (!cr2[CR2_SPISWAI])      mode_q <= MODE_WAIT;
                    else if (spe)               mode_q <= MODE_RUN;
                end
                default: mode_q <= MODE_RUN;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cr1    <= CR1_RESET;
            cr2    <= '0;
            br     <= '0;
            rxovf  <= 1'b0;
            spe_q  <= 1'b0;
            irq_q  <= 1'b0;
`ifdef APB_SPI_RX_THRESH_EN
            rxth_q <= 8'(FIFO_DEPTH);
`endif
        end else begin
            spe_q <= spe;
            irq_q <= irq_next;
            if (wr_commit) begin
                case (PADDR)
                    ADDR_CR1: cr1 <= PWDATA[7:0];
                    ADDR_CR2: cr2 <= PWDATA[7:0] & CR2_WMASK;
                    ADDR_BR:  br  <= PWDATA[7:0] & BR_WMASK;
                    ADDR_SR:  if (PWDATA[SR_RXOVF]) rxovf <= 1'b0;
`ifdef APB_SPI_RX_THRESH_EN
                    ADDR_RXTH: rxth_q <= PWDATA[7:0];
`endif
                    default: ;
                endcase
            end
            // A new overflow wins over a same-cycle write-1-to-clear.
            if (rx_valid && rx_full && !rx_pop) rxovf <= 1'b1;
        end
    end

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .push    (tx_push),
        .pop     (tx_valid & tx_ready),
        .flush   (flush),
        .din     (PWDATA),
        .dout    (tx_data),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .push    (rx_valid),
        .pop     (rx_pop),
        .flush   (flush),
        .din     (rx_data),
        .dout    (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

endmodule

// File: tb/tb_apb_spi_fifo_if.sv
// Directed-plus-random bench for apb_spi_fifo_if against a queue-based register model.
module tb_apb_spi_fifo_if;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          PSEL, PENABLE, PWRITE;
    logic [2:0]    PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_valid, tx_ready, rx_valid, tip, ss_n;
    logic [3:0]    spi_cfg;
    logic [2:0]    sppr, spr;
    logic [1:0]    spi_mode, apb_state;
    logic          irq;

    always #5 PCLK = ~PCLK;

    apb_spi_fifo_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .tip(tip), .ss_n(ss_n), .spi_cfg(spi_cfg), .sppr(sppr),
        .spr(spr), .spi_mode(spi_mode), .irq(irq), .apb_state(apb_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: register images plus the FIFO contents as queues.
    logic [7:0]    m_cr1, m_cr2, m_br, m_rxth;
    logic          m_rxovf;
    logic [DW-1:0] tx_exp_q[$];
    logic [DW-1:0] rx_exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cr1 = 8'h04; m_cr2 = 8'h00; m_br = 8'h00; m_rxovf = 1'b0; m_rxth = 8'(DEPTH);
        tx_exp_q.delete();
        rx_exp_q.delete();
    endtask

    function automatic logic [7:0] m_sr();
        logic th;
        th = 1'b0;
`ifdef APB_SPI_RX_THRESH_EN
        th = (rx_exp_q.size() >= int'(m_rxth)) && (m_rxth != 8'd0);
`endif
        return {rx_exp_q.size() != 0, 1'b0, tx_exp_q.size() == 0,
                ~ss_n & m_cr1[4] & m_cr2[4] & ~m_cr1[1],
                m_rxovf, tx_exp_q.size() == DEPTH, th, 1'b0};
    endfunction

    function automatic logic [7:0] m_cnt();
        int r, t;
        r = (rx_exp_q.size() > 15) ? 15 : rx_exp_q.size();
        t = (tx_exp_q.size() > 15) ? 15 : tx_exp_q.size();
        return {r[3:0], t[3:0]};
    endfunction

    function automatic logic m_err(input logic wr, input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2: return wr & tip;
            3'd5: return wr ? (tx_exp_q.size() == DEPTH) : (rx_exp_q.size() == 0);
`ifdef APB_SPI_RX_THRESH_EN
            3'd6: return 1'b0;
`else
            3'd6: return 1'b1;
`endif
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0: return m_cr1;
            3'd1: return m_cr2;
            3'd2: return m_br;
            3'd3: return m_sr();
            3'd4: return m_cnt();
            3'd5: return (rx_exp_q.size() != 0) ? rx_exp_q[0] : '0;
`ifdef APB_SPI_RX_THRESH_EN
            3'd6: return m_rxth;
`endif
            default: return '0;
        endcase
    endfunction

    // Starts and ends on a falling edge; the rising edge in between commits.
    task automatic apb(input logic wr, input logic [2:0] a, input logic [DW-1:0] wd,
                       input logic push_at_commit, input logic [DW-1:0] pd,
                       output logic [DW-1:0] rd, output logic err);
        int n;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        n = 0;
        while (!PREADY && n < 8) begin
            @(negedge PCLK);
            n++;
        end
        chk("pready", PREADY, 1);
        rd  = PRDATA;
        err = PSLVERR;
        if (push_at_commit) begin
            rx_valid = 1'b1;
            rx_data  = pd;
        end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d, input string tag);
        logic [DW-1:0] rd;
        logic err, exp_err;
        exp_err = m_err(1'b1, a);
        apb(1'b1, a, d, 1'b0, '0, rd, err);
        chk({tag, "_err"}, err, exp_err);
        if (!exp_err) begin
            case (a)
                3'd0: begin
                    if (m_cr1[6] && !d[6]) begin
                        tx_exp_q.delete();
                        rx_exp_q.delete();
                    end
                    m_cr1 = d;
                end
                3'd1: m_cr2 = d & 8'h1B;
                3'd2: m_br  = d & 8'h77;
                3'd3: if (d[3]) m_rxovf = 1'b0;
                3'd5: tx_exp_q.push_back(d);
                3'd6: m_rxth = d;
                default: ;
            endcase
        end
    endtask

    task automatic do_read(input logic [2:0] a, input string tag);
        logic [DW-1:0] rd, exp_d;
        logic err, exp_err;
        exp_err = m_err(1'b0, a);
        exp_d   = m_rd(a);
        apb(1'b0, a, '0, 1'b0, '0, rd, err);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_data"}, rd, exp_d);
        if (a == 3'd5 && !exp_err) void'(rx_exp_q.pop_front());
    endtask

    task automatic rx_push(input logic [DW-1:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge PCLK);
        rx_valid = 1'b0;
        if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(d);
        else m_rxovf = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd, pd, exp_d;
        logic err;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        tx_ready = 0; rx_valid = 0; rx_data = '0; tip = 0; ss_n = 1;
        PRESETn = 0;
        model_reset();
        repeat (3) @(negedge PCLK);
        chk("rst_pready", PREADY, 0);
        chk("rst_pslverr", PSLVERR, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_mode", spi_mode, 2'b00);
        chk("rst_cfg", spi_cfg, 4'b0010);
        chk("rst_baud", {sppr, spr}, 6'd0);
        PRESETn = 1;
        @(negedge PCLK);

        do_read(3'd0, "cr1_rst");
        do_read(3'd3, "sr_rst");
        do_read(3'd4, "cnt_rst");
        do_write(3'd1, 8'hFF, "cr2_w");
        do_read(3'd1, "cr2_mask");
        do_write(3'd1, 8'h00, "cr2_clr");
        for (int i = 0; i < 3; i++) begin
            do_write(3'd2, 8'($urandom_range(0, 255)), "br_w");
            do_read(3'd2, "br_rd");
            chk("baud_out", {sppr, spr}, {m_br[6:4], m_br[2:0]});
        end
        tip = 1;
        do_write(3'd0, 8'hFF, "cr1_tip");
        tip = 0;
        do_read(3'd0, "cr1_kept");
        do_read(3'd7, "addr7_rd");
        do_write(3'd7, 8'h55, "addr7_wr");
        do_read(3'd6, "addr6_rd");

        // Single TX word drains in one cycle when the shifter is ready.
        do_write(3'd0, 8'h40, "cr1_spe");
        tx_ready = 1;
        do_write(3'd5, 8'hA5, "dr_a5");
        chk("a5_valid", tx_valid, 1);
        chk("a5_data", tx_data, 8'hA5);
        void'(tx_exp_q.pop_front());
        @(negedge PCLK);
        chk("a5_gone", tx_valid, 0);
        tx_ready = 0;
        do_read(3'd3, "sr_sptef");

        // TX overfill: the fifth word is rejected.
        for (int i = 0; i < 5; i++) do_write(3'd5, 8'($urandom_range(0, 255)), "dr_fill");
        do_read(3'd4, "cnt_txfull");
        do_read(3'd3, "sr_txfull");
        tx_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_valid", tx_valid, 1);
            chk("drain_data", tx_data, tx_exp_q.pop_front());
            @(negedge PCLK);
        end
        tx_ready = 0;
        chk("drain_empty", tx_valid, 0);

        // RX overflow, in-order reads, empty read error, write-1-to-clear.
        for (int i = 0; i < 5; i++) rx_push(8'($urandom_range(0, 255)));
        do_read(3'd3, "sr_ovf");
        do_read(3'd4, "cnt_rx");
        for (int i = 0; i < 5; i++) do_read(3'd5, "dr_rd");
        do_write(3'd3, 8'h08, "sr_w1c");
        do_read(3'd3, "sr_clr");

        // Push and pop on the same edge of a full RX FIFO.
        for (int i = 0; i < DEPTH; i++) rx_push(8'($urandom_range(0, 255)));
        pd    = 8'($urandom_range(0, 255));
        exp_d = rx_exp_q[0];
        apb(1'b0, 3'd5, '0, 1'b1, pd, rd, err);
        chk("fullpp_data", rd, exp_d);
        chk("fullpp_err", err, 0);
        void'(rx_exp_q.pop_front());
        rx_exp_q.push_back(pd);
        do_read(3'd4, "cnt_fullpp");
        do_read(3'd3, "sr_fullpp");
        for (int i = 0; i < DEPTH; i++) do_read(3'd5, "dr_after_pp");

        // Push and failed pop on an empty RX FIFO: only the push lands.
        pd = 8'($urandom_range(0, 255));
        apb(1'b0, 3'd5, '0, 1'b1, pd, rd, err);
        chk("emptypp_err", err, 1);
        chk("emptypp_data", rd, 0);
        rx_exp_q.push_back(pd);
        do_read(3'd4, "cnt_emptypp");
        do_read(3'd5, "dr_emptypp");

        // spe falling edge flushes both FIFOs, keeps rxovf, enters WAIT then STOP.
        do_write(3'd5, 8'($urandom_range(0, 255)), "dr_pre_flush");
        do_write(3'd5, 8'($urandom_range(0, 255)), "dr_pre_flush");
        for (int i = 0; i < 5; i++) rx_push(8'($urandom_range(0, 255)));
        do_write(3'd0, 8'h00, "cr1_spe_off");
        chk("mode_still_run", spi_mode, 2'b00);
        @(negedge PCLK);
        chk("mode_wait", spi_mode, 2'b01);
        do_read(3'd4, "cnt_flush");
        do_read(3'd3, "sr_flush");
        do_write(3'd1, 8'h02, "cr2_swai");
        @(negedge PCLK);
        chk("mode_stop", spi_mode, 2'b10);
        do_write(3'd3, 8'h08, "sr_w1c2");
        do_write(3'd1, 8'h00, "cr2_clr2");

        // Interrupt sources and one-cycle registration.
        do_write(3'd0, 8'h20, "cr1_sptie");
        chk("irq_not_yet", irq, 0);
        @(negedge PCLK);
        chk("irq_sptef", irq, 1);
        do_write(3'd1, 8'h10, "cr2_modfen");
        do_write(3'd0, 8'h90, "cr1_mstr");
        ss_n = 0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("irq_modf", irq, 1);
        chk("cfg_mstr", spi_cfg, 4'b1000);
        do_read(3'd3, "sr_modf");
        ss_n = 1;
        do_write(3'd0, 8'h80, "cr1_spie");
        @(negedge PCLK);
        @(negedge PCLK);
        chk("irq_quiet", irq, 0);

`ifdef APB_SPI_RX_THRESH_EN
        do_write(3'd6, 8'd2, "rxth_w");
        do_read(3'd6, "rxth_rd");
        rx_push(8'($urandom_range(0, 255)));
        do_read(3'd3, "sr_th1");
        rx_push(8'($urandom_range(0, 255)));
        @(negedge PCLK);
        chk("irq_th", irq, 1);
        do_read(3'd3, "sr_th2");
        do_write(3'd6, 8'd0, "rxth_zero");
        do_read(3'd3, "sr_th0");
`endif

        // Reset in the middle of an access aborts it and empties the FIFOs.
        do_write(3'd5, 8'($urandom_range(0, 255)), "dr_pre_rst");
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 3'd4;
        @(negedge PCLK);
        PENABLE = 1;
        @(negedge PCLK);
        PRESETn = 0;
        #1;
        chk("abort_pready", PREADY, 0);
        chk("abort_prdata", PRDATA, 0);
        chk("abort_state", apb_state, 2'b00);
        PSEL = 0; PENABLE = 0;
        @(negedge PCLK);
        PRESETn = 1;
        model_reset();
        @(negedge PCLK);
        do_read(3'd4, "cnt_after_rst");
        do_read(3'd0, "cr1_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
